ahb_to_apb3_bridge_mslv: RTL

//  AHB-Lite slave to APB3 master bridge for NUM_SLAVES APB peripherals, successor to the single-slave bridge.

---
 rtl/ahb_apb_bridge_pkg.sv | 27 ++
 rtl/apb_slot_decoder.sv | 25 ++
 rtl/ahb_to_apb3_bridge_mslv.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ahb_apb_bridge_pkg.sv
// Shared types and constants for the AHB-Lite to APB3 bridge.
// Imported by the slot decoder and the bridge top.
package ahb_apb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WDATA  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    DONE   = 3'd4,
    ERR1   = 3'd5,
    ERR2   = 3'd6
  } bridge_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_slot_decoder.sv
// Maps an APB slave index to a one-hot select.
// Indices with no attached slave raise the bad flag.
module apb_slot_decoder
  import ahb_apb_bridge_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_W      = sel_width(NUM_SLAVES)
) (
  input  logic [SEL_W-1:0]      idx,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  bad
);

  always_comb begin
    sel = '0;
    bad = 1'b1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == SEL_W'(i)) begin
        sel[i] = 1'b1;
        bad    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ahb_to_apb3_bridge_mslv.sv
// AHB-Lite slave to multi-slave APB3 master bridge.
// One transfer in flight; wait states, PSLVERR and ACCESS timeout.
module ahb_to_apb3_bridge_mslv
  import ahb_apb_bridge_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int TRAN_WIDTH   = 3,
  parameter int NUM_SLAVES   = 4,
  parameter int SLV_ADDR_LSB = 12,
  parameter int TIMEOUT      = 16
) (
  input  logic                             H_CLK,
  input  logic                             H_RESET_n,
  input  logic                             H_SEL_APB,
  input  logic                             H_READY_IN,
  input  logic                             H_WRITE,
  input  logic [TRAN_WIDTH-1:0]            H_TRANS,
  input  logic [ADDR_WIDTH-1:0]            H_ADDR,
  input  logic [DATA_WIDTH-1:0]            H_WDATA,
  output logic                             H_READY_OUT,
  output logic                             H_RESP,
  output logic [DATA_WIDTH-1:0]            H_RDATA,
  output logic [NUM_SLAVES-1:0]            P_SELx,
  output logic                             P_ENABLE,
  output logic                             P_WRITE,
  output logic [ADDR_WIDTH-1:0]            P_ADDR,
  output logic [DATA_WIDTH-1:0]            P_WDATA,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] P_RDATA,
  input  logic [NUM_SLAVES-1:0]            P_READY,
  input  logic [NUM_SLAVES-1:0]            P_SLVERR
);

  localparam int SEL_W = sel_width(NUM_SLAVES);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  bridge_state_e state_q, state_d;

  logic [SEL_W-1:0]      idx_in, idx_q;
  logic [NUM_SLAVES-1:0] sel_in, sel_q;
  logic                  bad_in;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;

  logic valid_in, accept;
  logic rdy_sel, err_sel, tmo;
  logic unused_trans;

  assign idx_in = H_ADDR[SLV_ADDR_LSB +: SEL_W];

  apb_slot_decoder #(
    .NUM_SLAVES(NUM_SLAVES),
    .SEL_W     (SEL_W)
  ) u_dec (
    .idx(idx_in),
    .sel(sel_in),
    .bad(bad_in)
  );

  assign unused_trans = ^H_TRANS;

  assign valid_in = H_SEL_APB & H_READY_IN & H_TRANS[1];
  assign accept   = valid_in &
                    ((state_q == IDLE) | (state_q == DONE));

  // Only the addressed slave's handshake matters.
  assign rdy_sel = |(P_READY & sel_q);
  assign err_sel = |(P_SLVERR & sel_q);
  assign tmo     = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (valid_in) begin
          if (bad_in)       state_d = ERR1;
          else if (H_WRITE) state_d = WDATA;
          else              state_d = SETUP;
        end
      end
      WDATA:  state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (rdy_sel)  state_d = err_sel ? ERR1 : DONE;
        else if (tmo) state_d = ERR1;
      end
      ERR1:   state_d = ERR2;
      ERR2:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge H_CLK or negedge H_RESET_n) begin
    if (!H_RESET_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= H_ADDR;
        write_q <= H_WRITE;
        idx_q   <= idx_in;
        sel_q   <= sel_in;
      end
      if (state_q == WDATA) wdata_q <= H_WDATA;
      if (state_q == SETUP) begin
        cnt_q <= '0;
      end else if (state_q == ACCESS &&
                   cnt_q != CNT_W'(TIMEOUT)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == ACCESS && rdy_sel &&
          !err_sel && !write_q) begin
        rdata_q <= P_RDATA[idx_q*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign H_READY_OUT = (state_q == IDLE) |
                       (state_q == DONE) |
                       (state_q == ERR2);
  assign H_RESP = ((state_q == ERR1) | (state_q == ERR2)) ?
                  HRESP_ERROR : HRESP_OKAY;
  assign H_RDATA = rdata_q;

  assign P_SELx   = ((state_q == SETUP) | (state_q == ACCESS)) ?
                    sel_q : '0;
  assign P_ENABLE = (state_q == ACCESS);
  assign P_WRITE  = write_q;
  assign P_ADDR   = addr_q;
  assign P_WDATA  = wdata_q;

endmodule
